// File: rtl/weight_fifo_pkg.sv
// Shared constants and helpers for the weight lane FIFO and its skew delay lines.
// Lane packing helper `WF_LANE is used by weight_lane_fifo in both skew builds.
`define WF_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]

package weight_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_NUM_LANES  = 4;
   localparam int DEF_DEPTH      = 8;

   // A pointer must address DEPTH slots; count must also represent DEPTH itself.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/lane_skew_delay.sv
// Delay line of STAGES resettable data+valid registers for one weight lane.
// STAGES = 0 degenerates to a wire so lane 0 keeps single-cycle latency.
module lane_skew_delay
#(
   parameter int DATA_WIDTH = 8,
   parameter int STAGES     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid
);

   if (STAGES == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, flush};
      assign dout        = din;
      assign dout_valid  = din_valid;
   end else begin : g_chain
      logic signed [DATA_WIDTH-1:0] data_p [STAGES];
      logic                         vld_p  [STAGES];

      // stage boundary: every register shifts each cycle, there is no stall path
      always_ff @(posedge clk) begin
         if (reset || flush) begin
            for (int s = 0; s < STAGES; s++) begin
               data_p[s] <= '0;
               vld_p[s]  <= 1'b0;
            end
         end else begin
            data_p[0] <= $signed(din);
            vld_p[0]  <= din_valid;
            for (int s = 1; s < STAGES; s++) begin
               data_p[s] <= data_p[s-1];
               vld_p[s]  <= vld_p[s-1];
            end
         end
      end

      assign dout       = data_p[STAGES-1];
      assign dout_valid = vld_p[STAGES-1];
   end

endmodule

// File: rtl/weight_lane_fifo.sv
// Multi-lane circular weight buffer with push/pop handshake and registered read row.
// Defining WEIGHT_FIFO_SKEW_EN delays lane i by i extra cycles (systolic wavefront).
module weight_lane_fifo
   import weight_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_LANES  = DEF_NUM_LANES,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            flush,
   input  logic                            push,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] din,
   input  logic                            pop,
   output logic [NUM_LANES*DATA_WIDTH-1:0] dout,
   output logic [NUM_LANES-1:0]            dout_valid,
   output logic                            full,
   output logic                            empty,
   output logic [$clog2(DEPTH+1)-1:0]      count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);
   localparam int WW = NUM_LANES * DATA_WIDTH;

   logic [WW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt_q;
   logic          push_acc;
   logic          pop_acc;
   logic [WW-1:0] rd_data_p0;
   logic          rd_vld_p0;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Full is strict: a same-cycle pop never frees room for a push.
   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign push_acc = push & ~full;
   assign pop_acc  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push_acc, pop_acc})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc && !reset && !flush) mem[wr_ptr] <= din;
   end

   // stage p0: read register, holds its word between pops
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_data_p0 <= '0;
         rd_vld_p0  <= 1'b0;
      end else begin
         rd_vld_p0 <= pop_acc;
         if (pop_acc) rd_data_p0 <= mem[rd_ptr];
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
`ifdef WEIGHT_FIFO_SKEW_EN
      lane_skew_delay #(
         .DATA_WIDTH (DATA_WIDTH),
         .STAGES     (i)
      ) u_skew (
         .clk        (clk),
         .reset      (reset),
         .flush      (flush),
         .din        (`WF_LANE(rd_data_p0, i, DATA_WIDTH)),
         .din_valid  (rd_vld_p0),
         .dout       (`WF_LANE(dout, i, DATA_WIDTH)),
         .dout_valid (dout_valid[i])
      );
`else
      assign `WF_LANE(dout, i, DATA_WIDTH) = `WF_LANE(rd_data_p0, i, DATA_WIDTH);
      assign dout_valid[i] = rd_vld_p0;
`endif
   end

endmodule

// File: tb/tb_weight_lane_fifo.sv
// Randomised scoreboard bench for weight_lane_fifo (DEPTH=4, 4 lanes of 8 bits).
// Expected lane timing follows WEIGHT_FIFO_SKEW_EN when the bench is built with it.
module tb_weight_lane_fifo;

   localparam int DW = 8;
   localparam int NL = 4;
   localparam int DP = 4;
`ifdef WEIGHT_FIFO_SKEW_EN
   localparam int SK = 1;
`else
   localparam int SK = 0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [NL*DW-1:0] din = '0;
   logic [NL*DW-1:0] dout;
   logic [NL-1:0]    dout_valid;
   logic             full;
   logic             empty;
   logic [2:0]       count;

   weight_lane_fifo #(.DATA_WIDTH(DW), .NUM_LANES(NL), .DEPTH(DP)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (push),
      .din        (din),
      .pop        (pop),
      .dout       (dout),
      .dout_valid (dout_valid),
      .full       (full),
      .empty      (empty),
      .count      (count)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a plain queue, popped words logged with their pop edge.
   logic [NL*DW-1:0] model_q [$];
   logic [NL*DW-1:0] pop_word [$];
   int               pop_edge [$];
   int               head [NL];
   logic [DW-1:0]    exp_lane [NL];
   int               exp_count  = 0;
   int               flush_edge = 1;
   int               edge_cnt   = 0;
   int               checks     = 0;
   int               failures   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%h expected=%h", name, edge_cnt, act, exp);
      end
   endtask

   // Monitor: compares flags every cycle and pops per-lane expectations when they fall due.
   always @(posedge clk) begin
      #1;
      edge_cnt++;
      check("count", 32'(count), 32'(exp_count));
      check("full",  32'(full),  32'(exp_count == DP));
      check("empty", 32'(empty), 32'(exp_count == 0));
      for (int i = 0; i < NL; i++) begin
         logic             expv;
         logic [NL*DW-1:0] w;
         expv = (edge_cnt != flush_edge) && (head[i] < pop_word.size()) &&
                (pop_edge[head[i]] + i*SK == edge_cnt);
         check($sformatf("lane%0d_valid", i), 32'(dout_valid[i]), 32'(expv));
         if (edge_cnt == flush_edge) begin
            exp_lane[i] = '0;
         end else if (expv) begin
            w           = pop_word[head[i]];
            exp_lane[i] = w[i*DW +: DW];
            head[i]++;
         end
         check($sformatf("lane%0d_data", i), 32'(dout[i*DW +: DW]), 32'(exp_lane[i]));
      end
   end

   task automatic cyc(input bit r, input bit f, input bit p, input logic [NL*DW-1:0] d, input bit q);
      int e;
      @(negedge clk);
      reset = r;
      flush = f;
      push  = p;
      din   = d;
      pop   = q;
      e = edge_cnt + 1;
      if (r || f) begin
         model_q.delete();
         for (int i = 0; i < NL; i++) head[i] = pop_word.size();
         flush_edge = e;
      end else begin
         bit pa;
         bit qa;
         pa = p && (model_q.size() < DP);
         qa = q && (model_q.size() > 0);
         if (qa) begin
            pop_word.push_back(model_q.pop_front());
            pop_edge.push_back(e);
         end
         if (pa) model_q.push_back(d);
      end
      exp_count = model_q.size();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, '0, 0);
   endtask

   initial begin
      for (int i = 0; i < NL; i++) begin
         head[i]     = 0;
         exp_lane[i] = '0;
      end
      // reset then single push/pop
      cyc(1, 0, 0, '0, 0);
      cyc(0, 0, 1, 32'h04030201, 0);
      cyc(0, 0, 0, '0, 1);
      idle(5);
      // fill past full, then drain past empty
      for (int k = 1; k <= 5; k++) cyc(0, 0, 1, 32'(k), 0);
      for (int k = 0; k < 5; k++)  cyc(0, 0, 0, '0, 1);
      idle(5);
      // steady count=2 across pointer wrap
      cyc(0, 0, 1, 32'h10, 0);
      cyc(0, 0, 1, 32'h11, 0);
      for (int k = 0; k < 10; k++) cyc(0, 0, 1, 32'h12 + 32'(k), 1);
      cyc(0, 0, 0, '0, 1);
      cyc(0, 0, 0, '0, 1);
      idle(5);
      // push while full with concurrent pop is dropped
      for (int k = 0; k < 4; k++) cyc(0, 0, 1, 32'h50 + 32'(k), 0);
      cyc(0, 0, 1, 32'hAAAAAAAA, 1);
      // flush together with push while dout is valid
      cyc(0, 1, 1, 32'h77777777, 0);
      idle(2);
      for (int k = 0; k < 3; k++) cyc(0, 0, 1, 32'h60 + 32'(k), 0);
      cyc(0, 0, 0, '0, 1);
      cyc(1, 1, 1, 32'h88888888, 1);
      idle(2);
      // lane wavefront
      cyc(0, 0, 1, 32'h44332211, 0);
      cyc(0, 0, 0, '0, 1);
      idle(6);
      // randomised traffic with rare flush/reset
      for (int k = 0; k < 600; k++) begin
         bit r;
         bit f;
         r = ($urandom_range(0, 99) == 0);
         f = ($urandom_range(0, 39) == 0);
         cyc(r, f, $urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50);
      end
      idle(NL + 4);
      for (int i = 0; i < NL; i++)
         check($sformatf("lane%0d_drained", i), 32'(head[i]), 32'(pop_word.size()));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
